// File: rtl/gpio_pkg.sv
// gpio_pkg: register map shared by the GPIO bank, its pin cells and its users.
//   GPIO_DIR..GPIO_IRQ_STAT : word offsets of the eight bank registers
//   GPIO_ADDR_W             : default register address width
package gpio_pkg;

    localparam int GPIO_ADDR_W = 3;

    localparam logic [2:0] GPIO_DIR      = 3'd0;  // rw, 1 = output
    localparam logic [2:0] GPIO_OUT      = 3'd1;  // rw
    localparam logic [2:0] GPIO_OUT_SET  = 3'd2;  // wo, OUT |= wdata
    localparam logic [2:0] GPIO_OUT_CLR  = 3'd3;  // wo, OUT &= ~wdata
    localparam logic [2:0] GPIO_OUT_TGL  = 3'd4;  // wo, OUT ^= wdata
    localparam logic [2:0] GPIO_IN       = 3'd5;  // ro, synchronised pin level
    localparam logic [2:0] GPIO_IRQ_EN   = 3'd6;  // rw, masks irq only
    localparam logic [2:0] GPIO_IRQ_STAT = 3'd7;  // rw1c, sticky edge status

endpackage

// File: rtl/gpio_port_bank_if.sv
// gpio_port_bank_if: CPU-side register bus of the GPIO bank.
//   master : drives cs/wr_en/rd_en/addr/wdata, receives rdata/rdata_vld/irq
//   slave  : the bank itself
interface gpio_port_bank_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 3
);
    logic              cs;
    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              rdata_vld;
    logic              irq;

    modport master (output cs, wr_en, rd_en, addr, wdata,
                    input  rdata, rdata_vld, irq);
    modport slave  (input  cs, wr_en, rd_en, addr, wdata,
                    output rdata, rdata_vld, irq);
endinterface

// File: rtl/gpio_pin_cell.sv
// gpio_pin_cell: one GPIO pin.
//   clock, reset : rising edge clock, async active-high reset
//   dir, out     : drive enable / drive level from the bank registers
//   pin          : physical pad
//   sync_q       : pin level after the 2-flop synchroniser
//   edge_det     : sync_q differs from the previous cycle's sync_q
module gpio_pin_cell (
    input  logic clock,
    input  logic reset,
    input  logic dir,
    input  logic out,
    inout  wire  pin,
    output logic sync_q,
    output logic edge_det
);
    logic sync1_q;
    logic hist_q;

    assign pin = dir ? out : 1'bz;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync_q  <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= pin;
            sync_q  <= sync1_q;
            hist_q  <= sync_q;
        end
    end

    assign edge_det = sync_q ^ hist_q;
endmodule

// File: rtl/gpio_port_bank.sv
// gpio_port_bank: memory-mapped bank of NUM_PINS bidirectional pins.
//   clock, reset : rising edge clock, async active-high reset
//   bus          : register bus (cs, wr_en, rd_en, addr, wdata -> rdata, rdata_vld, irq)
//   io_pins      : physical pins, driven when the matching DIR bit is 1
// Holds DIR/OUT/IRQ_EN/IRQ_STAT, write decode, registered read mux and irq.
module gpio_port_bank
    import gpio_pkg::*;
#(
    parameter int NUM_PINS = 13,
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = GPIO_ADDR_W
) (
    input  logic                 clock,
    input  logic                 reset,
    gpio_port_bank_if.slave      bus,
    inout  wire  [NUM_PINS-1:0]  io_pins
);
    logic [NUM_PINS-1:0] dir_q, out_q, irq_en_q, irq_stat_q;
    logic [NUM_PINS-1:0] out_d, sync_in, edge_raw, w1c_mask, edge_set, rd_mux;
    logic [NUM_PINS-1:0] wbits;
    logic [7:0]          wsel;
    logic [1:0]          arm_q;
    logic                armed, wr, rd;
    logic                unused_wdata;

    assign wr    = bus.cs & bus.wr_en;
    assign rd    = bus.cs & bus.rd_en;
    assign wbits = bus.wdata[NUM_PINS-1:0];
    // register bits above NUM_PINS do not exist
    assign unused_wdata = ^bus.wdata;

    // The synchronisers fill from 0 after reset; a pin already high would
    // look like a rising edge, so edges are ignored until the fill is done.
    assign armed    = (arm_q == 2'd3);
    assign edge_set = armed ? edge_raw : {NUM_PINS{1'b0}};

    for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
        gpio_pin_cell u_cell (
            .clock    (clock),
            .reset    (reset),
            .dir      (dir_q[i]),
            .out      (out_q[i]),
            .pin      (io_pins[i]),
            .sync_q   (sync_in[i]),
            .edge_det (edge_raw[i])
        );
    end

    always_comb begin
        wsel = '0;
        for (int r = 0; r < 8; r++)
            wsel[r] = wr && (bus.addr == ADDR_W'(r));
    end

    always_comb begin
        out_d = out_q;
        if (wsel[GPIO_OUT])     out_d = wbits;
        if (wsel[GPIO_OUT_SET]) out_d = out_q | wbits;
        if (wsel[GPIO_OUT_CLR]) out_d = out_q & ~wbits;
        if (wsel[GPIO_OUT_TGL]) out_d = out_q ^ wbits;
    end

    assign w1c_mask = wsel[GPIO_IRQ_STAT] ? wbits : {NUM_PINS{1'b0}};

    // Read mux sees pre-write register values, so a same-cycle write+read
    // returns the old contents.
    always_comb begin
        rd_mux = '0;
        case (bus.addr)
            ADDR_W'(GPIO_DIR):      rd_mux = dir_q;
            ADDR_W'(GPIO_OUT):      rd_mux = out_q;
            ADDR_W'(GPIO_IN):       rd_mux = sync_in;
            ADDR_W'(GPIO_IRQ_EN):   rd_mux = irq_en_q;
            ADDR_W'(GPIO_IRQ_STAT): rd_mux = irq_stat_q;
            default:                rd_mux = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            arm_q         <= 2'd0;
            dir_q         <= '0;
            out_q         <= '0;
            irq_en_q      <= '0;
            irq_stat_q    <= '0;
            bus.irq       <= 1'b0;
            bus.rdata     <= '0;
            bus.rdata_vld <= 1'b0;
        end else begin
            if (!armed) arm_q <= arm_q + 2'd1;
            if (wsel[GPIO_DIR])    dir_q    <= wbits;
            if (wsel[GPIO_IRQ_EN]) irq_en_q <= wbits;
            out_q <= out_d;
            // set after clear: an edge in the W1C cycle stays recorded
            irq_stat_q    <= (irq_stat_q & ~w1c_mask) | edge_set;
            bus.irq       <= |(irq_stat_q & irq_en_q);
            bus.rdata_vld <= rd;
            if (rd) bus.rdata <= DATA_W'(rd_mux);
        end
    end
endmodule
